// File: rtl/rename_pkg.sv
// Shared rename types and widths.
// Used by reg_rename, reg_file and writeback.
package rename_pkg;
  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS_DEF = 64;
  localparam int PHYS_W = $clog2(NUM_PHYS_DEF);
  typedef logic [PHYS_W-1:0] phys_idx_t;
  typedef logic [4:0] arch_idx_t;
endpackage

// File: rtl/rename_free_list.sv
// Circular free-list FIFO of physical registers.
// Preloaded with NUM_ARCH..NUM_PHYS-1; head restores to commit head.
module rename_free_list
  import rename_pkg::*;
#(
  parameter int NUM_PHYS = NUM_PHYS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pop,
  input  logic                        push,
  input  logic [$clog2(NUM_PHYS)-1:0] push_phys,
  input  logic                        commit_adv,
  input  logic                        restore,
  output logic [$clog2(NUM_PHYS)-1:0] head_phys,
  output logic                        empty
);
  localparam int PW = $clog2(NUM_PHYS);
  localparam int D = NUM_PHYS - NUM_ARCH;
  localparam int PTR_W = $clog2(D);
  localparam int CW = $clog2(D + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t LAST = PTR_W'(D - 1);

  logic [PW-1:0] mem [D];
  ptr_t head, tail, chead;
  ptr_t head_n, tail_n, chead_n;
  cnt_t count, count_n, span;

  function automatic ptr_t inc(input ptr_t p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    tail_n = push ? inc(tail) : tail;
    chead_n = commit_adv ? inc(chead) : chead;
    head_n = pop ? inc(head) : head;
    count_n = count + cnt_t'(push) - cnt_t'(pop);
    span = '0;
    if (restore) begin
      head_n = chead_n;
      // tail == chead after restore means every entry is free
      if (tail_n >= chead_n)
        span = cnt_t'(tail_n) - cnt_t'(chead_n);
      else
        span = cnt_t'(tail_n) + cnt_t'(D) - cnt_t'(chead_n);
      count_n = (span == '0) ? cnt_t'(D) : span;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      chead <= '0;
      count <= cnt_t'(D);
      for (int i = 0; i < D; i++)
        mem[i] <= PW'(NUM_ARCH + i);
    end else begin
      head <= head_n;
      tail <= tail_n;
      chead <= chead_n;
      count <= count_n;
      if (push)
        mem[tail] <= push_phys;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push)
      assert (count != cnt_t'(D))
        else $error("rename_free_list: push while full");
  end

  assign head_phys = mem[head];
  assign empty = (count == '0);
endmodule

// File: rtl/reg_rename.sv
// Register rename stage: SRAT/RRAT, free list, busy vector.
// Define WB_BUSY_BYPASS_EN to bypass same-cycle writeback into src busy.
module reg_rename
  import rename_pkg::*;
#(
  parameter int NUM_PHYS = NUM_PHYS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4:0]                  in_rs,
  input  logic [4:0]                  in_rt,
  input  logic [4:0]                  in_rw,
  input  logic                        in_uses_rs,
  input  logic                        in_uses_rt,
  input  logic                        in_uses_rw,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NUM_PHYS)-1:0] rs_phys,
  output logic [$clog2(NUM_PHYS)-1:0] rt_phys,
  output logic [$clog2(NUM_PHYS)-1:0] rw_phys,
  output logic [$clog2(NUM_PHYS)-1:0] old_phys,
  output logic                        uses_rs,
  output logic                        uses_rt,
  output logic                        uses_rw,
  output logic                        rs_busy,
  output logic                        rt_busy,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_PHYS)-1:0] wb_phys,
  input  logic                        commit_valid,
  input  logic [4:0]                  commit_arch,
  input  logic [$clog2(NUM_PHYS)-1:0] commit_phys,
  input  logic [$clog2(NUM_PHYS)-1:0] commit_old_phys,
  input  logic                        flush,
  output logic [NUM_PHYS-1:0]         busy_bits
);
  localparam int PW = $clog2(NUM_PHYS);
  typedef logic [PW-1:0] pidx_t;

  pidx_t srat [NUM_ARCH];
  pidx_t rrat [NUM_ARCH];
  logic [NUM_PHYS-1:0] busy, busy_n;

  logic eff_rw, hs, pop, commit_en, push;
  logic fl_empty;
  pidx_t fl_head, rs_map, rt_map;
  logic rs_b, rt_b;

  assign eff_rw = in_uses_rw && (in_rw != 5'd0);
  assign in_ready = !flush && (!out_valid || out_ready)
                    && (!fl_empty || !eff_rw);
  assign hs = in_valid && in_ready;
  assign pop = hs && eff_rw;
  assign commit_en = commit_valid && (commit_arch != 5'd0);
  assign push = commit_en && (commit_old_phys != '0);

  assign rs_map = in_uses_rs ? srat[in_rs] : '0;
  assign rt_map = in_uses_rt ? srat[in_rt] : '0;

`ifdef WB_BUSY_BYPASS_EN
  assign rs_b = busy[rs_map] && !(wb_valid && wb_phys == rs_map);
  assign rt_b = busy[rt_map] && !(wb_valid && wb_phys == rt_map);
`else
  assign rs_b = busy[rs_map];
  assign rt_b = busy[rt_map];
`endif

  rename_free_list #(
    .NUM_PHYS(NUM_PHYS)
  ) u_free_list (
    .clk       (clk),
    .rst_n     (rst_n),
    .pop       (pop),
    .push      (push),
    .push_phys (commit_old_phys),
    .commit_adv(commit_en),
    .restore   (flush),
    .head_phys (fl_head),
    .empty     (fl_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        srat[i] <= PW'(i);
        rrat[i] <= PW'(i);
      end
    end else begin
      if (commit_en)
        rrat[commit_arch] <= commit_phys;
      if (flush) begin
        for (int i = 0; i < NUM_ARCH; i++)
          srat[i] <= (commit_en && commit_arch == 5'(i))
                     ? commit_phys : rrat[i];
      end else if (pop) begin
        srat[in_rw] <= fl_head;
      end
    end
  end

  // allocation set is applied after writeback clear so it wins
  always_comb begin
    busy_n = busy;
    if (wb_valid && wb_phys != '0)
      busy_n[wb_phys] = 1'b0;
    if (pop)
      busy_n[fl_head] = 1'b1;
    if (flush)
      busy_n = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rs_phys <= '0;
      rt_phys <= '0;
      rw_phys <= '0;
      old_phys <= '0;
      uses_rs <= 1'b0;
      uses_rt <= 1'b0;
      uses_rw <= 1'b0;
      rs_busy <= 1'b0;
      rt_busy <= 1'b0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (hs)        out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (hs) begin
        rs_phys <= rs_map;
        rt_phys <= rt_map;
        rw_phys <= eff_rw ? fl_head : '0;
        old_phys <= eff_rw ? srat[in_rw] : '0;
        uses_rs <= in_uses_rs;
        uses_rt <= in_uses_rt;
        uses_rw <= eff_rw;
        rs_busy <= rs_b;
        rt_busy <= rt_b;
      end
    end
  end

  assign busy_bits = busy;
endmodule

// File: tb/tb_reg_rename.sv
// Directed + random bench for reg_rename against a queue-based model.
// Honours WB_BUSY_BYPASS_EN when defined.
module tb_reg_rename;
  localparam int NP = 64;
  localparam int PW = $clog2(NP);
`ifdef WB_BUSY_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk, rst_n;
  logic in_valid, in_ready;
  logic [4:0] in_rs, in_rt, in_rw;
  logic in_uses_rs, in_uses_rt, in_uses_rw;
  logic out_valid, out_ready;
  logic [PW-1:0] rs_phys, rt_phys, rw_phys, old_phys;
  logic uses_rs, uses_rt, uses_rw, rs_busy, rt_busy;
  logic wb_valid;
  logic [PW-1:0] wb_phys;
  logic commit_valid;
  logic [4:0] commit_arch;
  logic [PW-1:0] commit_phys, commit_old_phys;
  logic flush;
  logic [NP-1:0] busy_bits;

  reg_rename #(.NUM_PHYS(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rw(in_rw),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt),
    .in_uses_rw(in_uses_rw),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs_phys(rs_phys), .rt_phys(rt_phys),
    .rw_phys(rw_phys), .old_phys(old_phys),
    .uses_rs(uses_rs), .uses_rt(uses_rt), .uses_rw(uses_rw),
    .rs_busy(rs_busy), .rt_busy(rt_busy),
    .wb_valid(wb_valid), .wb_phys(wb_phys),
    .commit_valid(commit_valid), .commit_arch(commit_arch),
    .commit_phys(commit_phys), .commit_old_phys(commit_old_phys),
    .flush(flush), .busy_bits(busy_bits)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int arch;
    int phys;
    int old;
  } rec_t;

  int checks, errors;
  int m_srat [32];
  int m_rrat [32];
  int m_free [$];
  int m_cfree [$];
  bit m_busy [NP];
  bit m_ov;
  int e_rs, e_rt, e_rw, e_old;
  bit e_urs, e_urt, e_urw, e_rsb, e_rtb;
  rec_t cq [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic idle();
    in_valid = 0; in_rs = 0; in_rt = 0; in_rw = 0;
    in_uses_rs = 0; in_uses_rt = 0; in_uses_rw = 0;
    out_ready = 1; wb_valid = 0; wb_phys = 0;
    commit_valid = 0; commit_arch = 0;
    commit_phys = 0; commit_old_phys = 0; flush = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_srat[i] = i;
      m_rrat[i] = i;
    end
    m_free.delete();
    for (int p = 32; p < NP; p++) m_free.push_back(p);
    m_cfree = m_free;
    for (int p = 0; p < NP; p++) m_busy[p] = 0;
    m_ov = 0;
    e_rs = 0; e_rt = 0; e_rw = 0; e_old = 0;
    e_urs = 0; e_urt = 0; e_urw = 0; e_rsb = 0; e_rtb = 0;
    cq.delete();
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    model_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy_bits", 64'(busy_bits), 64'(0));
    chk("rst_rw_phys", 64'(rw_phys), 64'(0));
    chk("rst_old_phys", 64'(old_phys), 64'(0));
    chk("rst_rs_phys", 64'(rs_phys), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1;
  endtask

  // one clock: inputs already applied at the negedge
  task automatic step();
    bit eff, rdy, hs;
    int rs_i, rt_i, rw_i, wbp, hp, old_v, rsp, rtp;
    logic [NP-1:0] bv;
    #1;
    rs_i = int'(in_rs);
    rt_i = int'(in_rt);
    rw_i = int'(in_rw);
    wbp = int'(wb_phys);
    eff = in_uses_rw && rw_i != 0;
    rdy = !flush && (!m_ov || out_ready) && (m_free.size() != 0 || !eff);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    hs = in_valid && rdy;
    old_v = m_srat[rw_i];
    if (hs) begin
      rsp = in_uses_rs ? m_srat[rs_i] : 0;
      rtp = in_uses_rt ? m_srat[rt_i] : 0;
      e_rs = rsp;
      e_rt = rtp;
      e_rsb = in_uses_rs && m_busy[rsp] && !(BYP && wb_valid && wbp == rsp);
      e_rtb = in_uses_rt && m_busy[rtp] && !(BYP && wb_valid && wbp == rtp);
      e_urs = in_uses_rs;
      e_urt = in_uses_rt;
      e_urw = eff;
      e_rw = eff ? m_free[0] : 0;
      e_old = eff ? old_v : 0;
    end
    hp = 0;
    if (hs && eff) begin
      hp = m_free.pop_front();
      m_srat[rw_i] = hp;
      cq.push_back('{rw_i, hp, old_v});
    end
    if (commit_valid && commit_arch != 0) begin
      m_rrat[int'(commit_arch)] = int'(commit_phys);
      void'(m_cfree.pop_front());
      if (commit_old_phys != 0) begin
        m_cfree.push_back(int'(commit_old_phys));
        m_free.push_back(int'(commit_old_phys));
      end
    end
    if (flush) begin
      m_srat = m_rrat;
      m_free = m_cfree;
      for (int p = 0; p < NP; p++) m_busy[p] = 0;
      m_ov = 0;
      cq.delete();
    end else begin
      if (wb_valid && wbp != 0) m_busy[wbp] = 0;
      if (hs && eff) m_busy[hp] = 1;
      m_ov = hs ? 1'b1 : (out_ready ? 1'b0 : m_ov);
    end
    for (int p = 0; p < NP; p++) bv[p] = m_busy[p];
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("rs_phys", 64'(rs_phys), 64'(e_rs));
    chk("rt_phys", 64'(rt_phys), 64'(e_rt));
    chk("rw_phys", 64'(rw_phys), 64'(e_rw));
    chk("old_phys", 64'(old_phys), 64'(e_old));
    chk("uses_rs", 64'(uses_rs), 64'(e_urs));
    chk("uses_rt", 64'(uses_rt), 64'(e_urt));
    chk("uses_rw", 64'(uses_rw), 64'(e_urw));
    chk("rs_busy", 64'(rs_busy), 64'(e_rsb));
    chk("rt_busy", 64'(rt_busy), 64'(e_rtb));
    chk("busy_bits", 64'(busy_bits), 64'(bv));
    @(negedge clk);
  endtask

  task automatic ren(input int rw, input int rs);
    in_valid = 1;
    in_rw = 5'(rw);
    in_uses_rw = 1;
    in_rs = 5'(rs);
    in_uses_rs = 1;
    step();
    idle();
  endtask

  task automatic do_commit();
    rec_t r;
    r = cq.pop_front();
    commit_valid = 1;
    commit_arch = 5'(r.arch);
    commit_phys = PW'(r.phys);
    commit_old_phys = PW'(r.old);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();

    // first rename and dependent lookup
    ren(5, 5);
    chk("r036_rw", 64'(rw_phys), 64'(32));
    chk("r036_old", 64'(old_phys), 64'(5));
    chk("r036_rs", 64'(rs_phys), 64'(5));
    in_valid = 1; in_rs = 5; in_uses_rs = 1;
    step();
    idle();
    chk("r036_rs2", 64'(rs_phys), 64'(32));
    chk("r036_rsb", 64'(rs_busy), 64'(1));

    // writeback racing a lookup
    do_reset();
    ren(5, 0);
    in_valid = 1; in_rs = 5; in_uses_rs = 1;
    wb_valid = 1; wb_phys = PW'(32);
    step();
    idle();
    chk("r038_rsb", 64'(rs_busy), 64'(!BYP));

    // exhaust the free list, then free one via commit
    do_reset();
    for (int i = 0; i < 32; i++)
      ren(((i + 4) % 31) + 1, int'($urandom_range(0, 31)));
    in_valid = 1; in_rw = 1; in_uses_rw = 1;
    #1;
    chk("r037_full", 64'(in_ready), 64'(0));
    step();
    idle();
    do_commit();
    step();
    idle();
    in_valid = 1; in_rw = 1; in_uses_rw = 1;
    #1;
    chk("r037_ready", 64'(in_ready), 64'(1));
    step();
    idle();
    chk("r037_rw", 64'(rw_phys), 64'(5));

    // partial commit then flush
    do_reset();
    ren(3, 0);
    ren(4, 0);
    do_commit();
    step();
    idle();
    flush = 1;
    step();
    idle();
    chk("r039_busy", 64'(busy_bits), 64'(0));
    in_valid = 1; in_rs = 4; in_uses_rs = 1;
    in_rw = 6; in_uses_rw = 1;
    step();
    idle();
    chk("r039_srat4", 64'(rs_phys), 64'(4));
    chk("r039_alloc", 64'(rw_phys), 64'(33));

    // rw = r0 is not renamed
    do_reset();
    in_valid = 1; in_rw = 0; in_uses_rw = 1;
    step();
    idle();
    chk("r040_uses_rw", 64'(uses_rw), 64'(0));
    chk("r040_rw", 64'(rw_phys), 64'(0));
    ren(7, 0);
    chk("r040_next", 64'(rw_phys), 64'(32));

    // downstream stall
    do_reset();
    out_ready = 0;
    in_valid = 1; in_rw = 5; in_uses_rw = 1;
    step();
    in_rw = 6;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("r041_in_ready", 64'(in_ready), 64'(0));
      step();
      chk("r041_hold", 64'(rw_phys), 64'(32));
    end
    out_ready = 1;
    step();
    idle();
    chk("r041_next", 64'(rw_phys), 64'(33));

    // random traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_rs = 5'($urandom_range(0, 31));
      in_rt = 5'($urandom_range(0, 31));
      in_rw = 5'($urandom_range(0, 31));
      in_uses_rs = 1'($urandom_range(0, 1));
      in_uses_rt = 1'($urandom_range(0, 1));
      in_uses_rw = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_phys = PW'($urandom_range(0, NP - 1));
      commit_valid = 0; commit_arch = 0;
      commit_phys = 0; commit_old_phys = 0;
      if (cq.size() != 0 && $urandom_range(0, 2) == 0)
        do_commit();
      flush = ($urandom_range(0, 49) == 0);
      step();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_rename.md
REG_RENAME -- requirements
Module: reg_rename

Interface
REQ-001 The module SHALL have parameter NUM_PHYS, default 64, giving the physical register count; it SHALL be a power of 2 and greater than 32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have the following decode-side ports:
- in_valid, input, 1 bit.
- in_ready, output, 1 bit.
- in_rs, input, 5 bits.
- in_rt, input, 5 bits.
- in_rw, input, 5 bits.
- in_uses_rs, input, 1 bit.
- in_uses_rt, input, 1 bit.
- in_uses_rw, input, 1 bit.
REQ-005 The module SHALL have the following register-file-side ports:
- out_valid, output, 1 bit.
- out_ready, input, 1 bit.
- rs_phys, output, PHYS_W bits.
- rt_phys, output, PHYS_W bits.
- rw_phys, output, PHYS_W bits.
- old_phys, output, PHYS_W bits.
- uses_rs, output, 1 bit.
- uses_rt, output, 1 bit.
- uses_rw, output, 1 bit.
- rs_busy, output, 1 bit.
- rt_busy, output, 1 bit.
REQ-006 The module SHALL have wb_valid (input, 1 bit) and wb_phys (input, PHYS_W bits): a writeback completed to that physical register.
REQ-007 The module SHALL have the following commit ports:
- commit_valid, input, 1 bit.
- commit_arch, input, 5 bits.
- commit_phys, input, PHYS_W bits.
- commit_old_phys, input, PHYS_W bits.
REQ-008 The module SHALL have port flush, input, 1 bit: squash all uncommitted renames.
REQ-009 The module SHALL have port busy_bits, output, NUM_PHYS bits: the live busy vector.

Function
REQ-010 The module SHALL hold a speculative map (SRAT, 32 x PHYS_W), a retirement map (RRAT, 32 x PHYS_W), a circular free-list FIFO of depth NUM_PHYS-32, and a busy vector.
REQ-011 Effective rw use SHALL be in_uses_rw && in_rw != 0; architectural register 0 SHALL never be renamed, and physical register 0 SHALL never be allocated, freed, or marked busy.
REQ-012 in_ready SHALL equal !flush && (!out_valid || out_ready) && (free_count != 0 || !effective rw use).
REQ-013 On the in_valid && in_ready handshake, the module SHALL register the following in the output stage, with 1-cycle latency:
- rs_phys and rt_phys from the SRAT, read before this instruction's rw update.
- old_phys = SRAT[in_rw].
- rw_phys = free-list head.
REQ-014 On the same handshake with effective rw use, the module SHALL pop the free list, set SRAT[in_rw] = rw_phys, and set busy[rw_phys].
REQ-015 Without effective rw use, the module SHALL deassert uses_rw and drive rw_phys and old_phys to 0.
REQ-016 uses_rs and uses_rt SHALL register the input flags.
REQ-017 rs_busy and rt_busy SHALL register the busy bits of the looked-up registers.
REQ-018 An unused source SHALL output phys 0 with its busy output 0.
REQ-019 out_valid SHALL set on handshake, clear on out_ready without a new handshake, and clear on flush.
REQ-020 A wb_valid with wb_phys != 0 SHALL clear busy[wb_phys] at the clock edge.
REQ-021 If allocation and writeback name the same register in one cycle, the set SHALL win.
REQ-022 A commit_valid with commit_arch != 0 SHALL set RRAT[commit_arch] = commit_phys and advance the commit head pointer.
REQ-023 The same commit SHALL push commit_old_phys to the free-list tail unless it is 0.
REQ-024 A simultaneous pop and push SHALL leave free_count unchanged; the head and tail pointers SHALL wrap modulo NUM_PHYS-32.
REQ-025 A push when free_count == NUM_PHYS-32 is illegal, and the module SHALL flag it with a simulation assertion.
REQ-026 On flush, the module SHALL apply the following updates at the edge:
- SRAT SHALL be copied from RRAT, incorporating a same-cycle commit.
- The head pointer SHALL be restored to the commit head pointer.
- free_count SHALL be recomputed from the pointers.
- All busy bits SHALL clear.
- out_valid SHALL clear.
REQ-027 On flush, the same-cycle decode and wb_valid SHALL be ignored, and the same-cycle commit SHALL be honoured.

Reset
REQ-028 On rst_n low, the module SHALL immediately reset the maps: SRAT[i] = RRAT[i] = i for i = 0..31.
REQ-029 On rst_n low, the free list SHALL hold 32..NUM_PHYS-1 in order, with head = commit head = 0, tail = 0 (full), and free_count = NUM_PHYS-32.
REQ-030 On rst_n low, busy_bits SHALL be 0, out_valid 0, and all phys outputs 0.
REQ-031 Reset deasserted mid-operation SHALL discard all state, with no partial recovery.

Configuration
REQ-032 With WB_BUSY_BYPASS_EN defined, a wb_valid to the register being looked up in the same cycle SHALL yield a registered rs_busy/rt_busy of 0.
REQ-033 Without WB_BUSY_BYPASS_EN, rs_busy/rt_busy SHALL reflect the pre-edge busy bit, and may be 1 for a register written back that same cycle.

Structure
REQ-034 The package rename_pkg SHALL hold NUM_ARCH=32, PHYS_W=$clog2(NUM_PHYS) and typedef phys_idx_t, shared with reg_file and writeback.
REQ-035 The free list SHALL be a sub-module, rename_free_list: a circular FIFO with reset preload, pop, push, and head restore.

Verification
REQ-036 The bench SHALL check: after reset, rename rw=5, rs=5 -> rw_phys=32, old_phys=5, rs_phys=5; next rename of rs=5 -> rs_phys=32, rs_busy=1.
REQ-037 The bench SHALL check: 32 renames without commit (NUM_PHYS=64) -> in_ready=0 on the 33rd; one commit with old_phys=5 -> in_ready=1 and the next rw_phys=5.
REQ-038 The bench SHALL check: wb_valid to phys 32 in the same cycle as a lookup of rs mapped to 32 -> rs_busy=0 with WB_BUSY_BYPASS_EN, 1 without.
REQ-039 The bench SHALL check: rename rw=3 -> 32 and rw=4 -> 33, commit only the first, then flush -> SRAT[4]=4, next alloc=33, busy_bits all 0.
REQ-040 The bench SHALL check: in_rw=0 with in_uses_rw=1 -> uses_rw=0, free_count unchanged.
REQ-041 The bench SHALL check: out_ready held 0 for 3 cycles -> outputs stable, in_ready=0, no free-list pop.
